// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressed 64-bit data memory, combinational read, synchronous write
// Optional macro DATA_MEM_READ_GATE_EN forces Read_Data to zero while Mem_Read is low.
module data_memory #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Mem_Addr,
  input  logic [63:0] Write_Data,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  output logic [63:0] Read_Data,
  output logic [63:0] va11,
  output logic [63:0] va12,
  output logic [63:0] va13,
  output logic [63:0] va14,
  output logic [63:0] va15,
  output logic [63:0] va16,
  output logic [63:0] va17,
  output logic [63:0] va18
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] base;
  logic [63:0]   raw_data;
  logic [63:0]   view [8];
  logic          unused_addr_hi;

  // Only the low AW address bits select a byte; everything above wraps.
  assign base           = Mem_Addr[AW-1:0];
  assign unused_addr_hi = ^Mem_Addr[63:AW];

  function automatic logic [7:0] preset_byte(input int b);
    logic [7:0] v;
    case (b / 8)
      0:       v = 8'd9;
      1:       v = 8'd3;
      2:       v = 8'd7;
      3:       v = 8'd1;
      4:       v = 8'd8;
      5:       v = 8'd2;
      6:       v = 8'd10;
      7:       v = 8'd5;
      8:       v = 8'd4;
      9:       v = 8'd6;
      default: v = 8'd0;
    endcase
    if ((b % 8) != 0) v = 8'd0;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[AW'(i)] <= preset_byte(i);
      end
    end else if (Mem_Write) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= Write_Data[8*i +: 8];
      end
    end
  end

  always_comb begin
    raw_data = '0;
    for (int i = 0; i < 8; i++) begin
      raw_data[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      view[k] = '0;
      for (int i = 0; i < 8; i++) begin
        view[k][8*i +: 8] = mem[AW'(8*k + i)];
      end
    end
  end

  assign va11 = view[0];
  assign va12 = view[1];
  assign va13 = view[2];
  assign va14 = view[3];
  assign va15 = view[4];
  assign va16 = view[5];
  assign va17 = view[6];
  assign va18 = view[7];

`ifdef DATA_MEM_READ_GATE_EN
  assign Read_Data = Mem_Read ? raw_data : 64'd0;
`else
  logic unused_read;
  assign unused_read = Mem_Read;
  assign Read_Data   = raw_data;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [63:0] Read_Data;
  logic [63:0] va [8];

  int n_cmp = 0;
  int n_err = 0;

  data_memory #(.MEM_BYTES(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .Mem_Read   (Mem_Read),
    .Mem_Write  (Mem_Write),
    .Read_Data  (Read_Data),
    .va11       (va[0]),
    .va12       (va[1]),
    .va13       (va[2]),
    .va14       (va[3]),
    .va15       (va[4]),
    .va16       (va[5]),
    .va17       (va[6]),
    .va18       (va[7])
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    Mem_Addr   = a;
    Write_Data = d;
    Mem_Write  = 1'b1;
    tick();
    Mem_Write  = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp_tab [10];
    exp_tab = '{64'd9, 64'd3, 64'd7, 64'd1, 64'd8, 64'd2, 64'd10, 64'd5, 64'd4, 64'd6};
    do_reset();
    Mem_Read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      Mem_Addr = 64'(8 * k);
      #1;
      n_cmp++;
      if (Read_Data !== exp_tab[k]) begin
        n_err++;
        $display("FAIL reset_dw%0d got %h expected %h", k, Read_Data, exp_tab[k]);
      end
    end
    Mem_Addr = 64'd80;
    #1;
    n_cmp++;
    if (Read_Data !== 64'd0) begin
      n_err++;
      $display("FAIL reset_addr80 got %h expected 0", Read_Data);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (va[k] !== exp_tab[k]) begin
        n_err++;
        $display("FAIL reset_va1%0d got %h expected %h", k + 1, va[k], exp_tab[k]);
      end
    end
  endtask

  task automatic test_write_read();
    Mem_Read   = 1'b1;
    Mem_Addr   = 64'd16;
    Write_Data = 64'h1122334455667788;
    Mem_Write  = 1'b1;
    #1;
    n_cmp++;
    if (Read_Data !== 64'd7) begin
      n_err++;
      $display("FAIL wr_before_edge got %h expected 7", Read_Data);
    end
    tick();
    Mem_Write = 1'b0;
    n_cmp++;
    if (Read_Data !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL wr_after_edge got %h expected 1122334455667788", Read_Data);
    end
    n_cmp++;
    if (va[2] !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL wr_va13 got %h expected 1122334455667788", va[2]);
    end
    Mem_Addr = 64'd17;
    #1;
    n_cmp++;
    if (Read_Data !== 64'h0111223344556677) begin
      n_err++;
      $display("FAIL misaligned_17 got %h expected 0111223344556677", Read_Data);
    end
  endtask

  task automatic test_back_to_back();
    do_write(64'd96, 64'hA5A5_0000_1234_5678);
    do_write(64'd104, 64'h0F0F_F0F0_CAFE_BEEF);
    Mem_Read = 1'b1;
    Mem_Addr = 64'd96;
    #1;
    n_cmp++;
    if (Read_Data !== 64'hA5A5_0000_1234_5678) begin
      n_err++;
      $display("FAIL b2b_first got %h expected a5a5000012345678", Read_Data);
    end
    Mem_Addr = 64'd104;
    #1;
    n_cmp++;
    if (Read_Data !== 64'h0F0F_F0F0_CAFE_BEEF) begin
      n_err++;
      $display("FAIL b2b_second got %h expected 0f0ff0f0cafebeef", Read_Data);
    end
  endtask

  task automatic test_bubble_sort();
    logic [63:0] a, b;
    do_reset();
    Mem_Read = 1'b1;
    for (int p = 0; p < 9; p++) begin
      for (int j = 0; j < 9 - p; j++) begin
        Mem_Addr = 64'(8 * j);
        tick();
        a = Read_Data;
        Mem_Addr = 64'(8 * j + 8);
        tick();
        b = Read_Data;
        if (a > b) begin
          do_write(64'(8 * j), b);
          do_write(64'(8 * j + 8), a);
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      Mem_Addr = 64'(8 * k);
      #1;
      n_cmp++;
      if (Read_Data !== 64'(k + 1)) begin
        n_err++;
        $display("FAIL sort_dw%0d got %h expected %0d", k, Read_Data, k + 1);
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (va[k] !== 64'(k + 1)) begin
        n_err++;
        $display("FAIL sort_va1%0d got %h expected %0d", k + 1, va[k], k + 1);
      end
    end
  endtask

  task automatic test_reset_priority();
    Mem_Addr   = 64'd0;
    Write_Data = 64'hDEAD_BEEF_DEAD_BEEF;
    Mem_Write  = 1'b1;
    reset      = 1'b0;
    tick();
    reset      = 1'b1;
    Mem_Write  = 1'b0;
    Mem_Read   = 1'b1;
    #1;
    n_cmp++;
    if (Read_Data !== 64'd9) begin
      n_err++;
      $display("FAIL rstprio_dw0 got %h expected 9", Read_Data);
    end
    Mem_Addr = 64'd72;
    #1;
    n_cmp++;
    if (Read_Data !== 64'd6) begin
      n_err++;
      $display("FAIL rstprio_dw9 got %h expected 6", Read_Data);
    end
    n_cmp++;
    if (va[7] !== 64'd5) begin
      n_err++;
      $display("FAIL rstprio_va18 got %h expected 5", va[7]);
    end
  endtask

  task automatic test_wrap();
    do_write(64'd124, 64'hFFFF_FFFF_FFFF_FFFF);
    Mem_Read = 1'b1;
    n_cmp++;
    if (va[0] !== 64'h0000_0000_FFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_va11 got %h expected 00000000ffffffff", va[0]);
    end
    Mem_Addr = 64'd124;
    #1;
    n_cmp++;
    if (Read_Data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_read124 got %h expected ffffffffffffffff", Read_Data);
    end
    Mem_Addr = 64'd120;
    #1;
    n_cmp++;
    if (Read_Data !== 64'hFFFF_FFFF_0000_0000) begin
      n_err++;
      $display("FAIL wrap_read120 got %h expected ffffffff00000000", Read_Data);
    end
    Mem_Addr = 64'hFFFF_0000_0000_0000;
    #1;
    n_cmp++;
    if (Read_Data !== 64'h0000_0000_FFFF_FFFF) begin
      n_err++;
      $display("FAIL upper_addr_ignored got %h expected 00000000ffffffff", Read_Data);
    end
  endtask

  task automatic test_read_gate();
    Mem_Addr = 64'd8;
    Mem_Read = 1'b0;
    #1;
`ifdef DATA_MEM_READ_GATE_EN
    n_cmp++;
    if (Read_Data !== 64'd0) begin
      n_err++;
      $display("FAIL read_gated got %h expected 0", Read_Data);
    end
`else
    n_cmp++;
    if (Read_Data !== 64'd3) begin
      n_err++;
      $display("FAIL read_ungated got %h expected 3", Read_Data);
    end
`endif
    n_cmp++;
    if (va[1] !== 64'd3) begin
      n_err++;
      $display("FAIL va12_not_gated got %h expected 3", va[1]);
    end
    Mem_Read = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    Mem_Addr   = '0;
    Write_Data = '0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_bubble_sort();
    test_reset_priority();
    test_wrap();
    test_read_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

endmodule
